serial_full_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing A − B − Bin, LSB first, one bit per clock.
- Built around a single full-subtractor cell and a borrow flip-flop.
- It is the subtract-direction counterpart of the team's full-adder datapath.
- Used where area matters more than latency; start/done handshake toward a controlling FSM or testbench.

---
 rtl/serial_full_subtractor.sv | 148 ++++++++++++++
 tb/tb_serial_full_subtractor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_full_subtractor.sv
// Bit-serial A - B - Bin subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, one bit per clock, start/done handshake.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Returns {borrow_out, difference} for one bit position.
  function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bi);
    fs_cell = {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_sh_r;
  logic [WIDTH-1:0] diff_sh_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic [1:0]       cell_s;
  logic             last_s;
  logic             load_s;
  logic             step_s;
  logic             finish_s;

  assign cell_s = fs_cell(a_sh_r[0], b_sh_r[0], borrow_r);
  assign last_s = (cnt_r == LAST_CNT);
  // New difference bit enters at the MSB; the oldest partial bit falls off the LSB.
  assign diff_sh_next_s = WIDTH'({cell_s[0], diff_sh_r} >> 1'b1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath control decoded from the current state.
  always_comb begin
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = start;
      end
      SHIFT: begin
        step_s   = 1'b1;
        finish_s = last_s;
      end
      default: begin
        load_s   = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
      end
    endcase
  end

  // Operand shifters, borrow flop, bit counter and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r    <= {WIDTH{1'b0}};
      b_sh_r    <= {WIDTH{1'b0}};
      diff_sh_r <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      borrow_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      diff_r    <= {WIDTH{1'b0}};
      bout_r    <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (load_s) begin
        a_sh_r   <= a;
        b_sh_r   <= b;
        borrow_r <= bin;
        cnt_r    <= {CNT_W{1'b0}};
        busy_r   <= 1'b1;
      end else if (step_s) begin
        a_sh_r    <= a_sh_r >> 1'b1;
        b_sh_r    <= b_sh_r >> 1'b1;
        borrow_r  <= cell_s[1];
        cnt_r     <= cnt_r + CNT_ONE;
        diff_sh_r <= diff_sh_next_s;
        // Results only move on the final bit so they hold through the next operation.
        if (finish_s) begin
          busy_r <= 1'b0;
          diff_r <= diff_sh_next_s;
          bout_r <= cell_s[1];
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Scoreboard bench for serial_full_subtractor at WIDTH=8 and WIDTH=1, sharing clock,
// reset and start; expected results come from plain integer subtraction.
module tb_serial_full_subtractor;

  bit         clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;

  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  typedef struct {
    logic [8:0] res;
    int         due;
  } exp_t;

  exp_t       q8[$];
  exp_t       q1[$];
  int         cyc      = 0;
  int         idle8    = 0;
  int         idle1    = 0;
  int         rst_edge = -1;
  int         checks   = 0;
  int         fails    = 0;
  logic [8:0] hold8    = 9'h000;
  logic [8:0] hold1    = 9'h000;

  logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

  always #5 clk = ~clk;

  serial_full_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_full_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a[0:0]), .b(b[0:0]), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  // Reference: {borrow, (x - y - bi) mod 2^w} using integer arithmetic.
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y,
                                         input logic bi, input int w);
    int mask;
    int r;
    mask = (1 << w) - 1;
    r = (int'(x) & mask) - (int'(y) & mask) - int'(bi);
    ref_sub = {(r < 0) ? 1'b1 : 1'b0, 8'(r & mask)};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model side: decide acceptance from the handshake rules and queue the expected result.
  always @(posedge clk) begin
    if (rst) begin
      q8.delete();
      q1.delete();
      idle8    <= cyc + 2;
      idle1    <= cyc + 2;
      rst_edge <= cyc + 1;
    end else begin
      if (start && (cyc + 1 >= idle8)) begin
        q8.push_back('{ref_sub(a, b, bin, 8), cyc + 1 + 8});
        idle8 <= cyc + 1 + 9;
      end
      if (start && (cyc + 1 >= idle1)) begin
        q1.push_back('{ref_sub(a, b, bin, 1), cyc + 1 + 1});
        idle1 <= cyc + 1 + 2;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic mon(input string tag, input logic dn, input logic [7:0] df, input logic bo,
                     input logic bz, ref exp_t q[$], ref logic [8:0] hold, input int idle);
    exp_t e;
    check({tag, "_busy"}, 64'(bz), 64'((cyc + 2 <= idle) ? 1 : 0));
    if (rst_edge == cyc) hold = 9'h000;
    if (dn) begin
      if (q.size() == 0) begin
        check({tag, "_unexpected_done"}, 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        check({tag, "_done_cycle"}, 64'(cyc), 64'(e.due));
        hold = e.res;
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check({tag, "_missing_done"}, 64'(0), 64'(1));
    end
    check({tag, "_result"}, 64'({bo, df}), 64'(hold));
  endtask

  // Monitor: compare both DUTs away from the active edge.
  always @(negedge clk) begin
    mon("w8", done8, diff8, bout8, busy8, q8, hold8, idle8);
    mon("w1", done1, {7'b0, diff1}, bout1, busy1, q1, hold1, idle1);
  end

  task automatic wait_done8(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (done8) ok = 1'b1;
    end
    if (!ok) check({nm, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic bi,
                    input logic [7:0] ed, input logic eb, input string nm);
    bit ok;
    @(negedge clk);
    a = x; b = y; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    wait_done8(nm, ok);
    if (ok) begin
      check({nm, "_diff"}, 64'(diff8), 64'(ed));
      check({nm, "_bout"}, 64'(bout8), 64'(eb));
    end
  endtask

  initial begin
    bit ok;
    int acc;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy8), 64'(0));
    check("reset_done", 64'(done8), 64'(0));
    check("reset_diff", 64'(diff8), 64'(0));
    check("reset_bout", 64'(bout8), 64'(0));
    rst = 1'b0;

    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "5m3");
    op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "3m5");
    op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "0m0b");
    op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FFmFFb");

    // Back-to-back: start held high through busy and the done cycle.
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h10; b = 8'h10;
    wait_done8("b2b_first", ok);
    if (ok) begin
      check("b2b_first_diff", 64'(diff8), 64'(8'h7F));
      check("b2b_first_bout", 64'(bout8), 64'(0));
    end
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    wait_done8("b2b_second", ok);
    if (ok) begin
      check("b2b_second_diff", 64'(diff8), 64'(8'h00));
      check("b2b_second_bout", 64'(bout8), 64'(0));
      check("b2b_second_latency", 64'(cyc - acc), 64'(8));
    end

    // Reset at the fourth edge after acceptance.
    repeat (3) @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy8), 64'(0));
    check("midrst_done", 64'(done8), 64'(0));
    check("midrst_diff", 64'(diff8), 64'(0));
    check("midrst_bout", 64'(bout8), 64'(0));
    repeat (12) @(negedge clk);
    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "after_rst");

    // WIDTH=1 truth table sweep, index = {a, b, bin}.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      @(negedge clk);
      a = {7'b0, iv[2]}; b = {7'b0, iv[1]}; bin = iv[0]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("w1_done_pulse", 64'(done1), 64'(1));
      check("w1_truth", 64'({bout1, diff1}), 64'(tt[i]));
      repeat (10) @(negedge clk);
    end

    // Random traffic with occasional resets; the scoreboard does the checking.
    repeat (400) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 63) == 0);
      start = 1'($urandom);
      a     = 8'($urandom);
      b     = 8'($urandom);
      bin   = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    check("w8_queue_drained", 64'(q8.size()), 64'(0));
    check("w1_queue_drained", 64'(q1.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
